// File: rtl/stopwatch_lap_bank.sv
// stopwatch_lap_bank: M:SS.t stopwatch with a NUM_LAPS-deep lap memory and a
// multiplexed, registered 4-digit active-low 7-segment driver.
// Buttons arrive as clean one-cycle pulses; time saturates at MAX_MIN:59.9.
module stopwatch_lap_bank #(
    parameter int TICK_DIV = 10_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int NUM_LAPS = 4,
    parameter int MAX_MIN  = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap,
    input  logic [3:0] sel,
    output logic [3:0] DIGIT,
    output logic [6:0] DISPLAY,
    output logic       running,
    output logic [3:0] lap_count,
    output logic       laps_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_ten;
        logic [3:0] sec_one;
        logic [3:0] tenth;
    } bcd_time_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    LAPS_N     = 4'(NUM_LAPS);
    localparam bcd_time_t     FULL_SCALE = {4'(MAX_MIN), 4'd5, 4'd9, 4'd9};
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;
    localparam logic [6:0]    SEG_ZERO   = 7'b1000000;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Add 0.1 s with ripple carry tenth -> sec_one -> sec_ten -> min.
    // Never called at full scale, so min cannot overflow.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.tenth != 4'd9) begin
            r.tenth = t.tenth + 4'd1;
        end else begin
            r.tenth = 4'd0;
            if (t.sec_one != 4'd9) begin
                r.sec_one = t.sec_one + 4'd1;
            end else begin
                r.sec_one = 4'd0;
                if (t.sec_ten != 4'd5) begin
                    r.sec_ten = t.sec_ten + 4'd1;
                end else begin
                    r.sec_ten = 4'd0;
                    r.min     = t.min + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stopwatch core
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    bcd_time_t       time_q, time_d;
    logic [3:0]      lap_count_q, lap_count_d;

    logic            tick;
    logic            full_scale;
    logic            laps_full_w;
    logic            lap_we;
    logic            clear;

    assign tick        = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign full_scale  = (time_q == FULL_SCALE);
    assign laps_full_w = (lap_count_q == LAPS_N);

    // Next-state, prescaler, time and lap-count decisions for the three states.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        time_d      = time_q;
        lap_count_d = lap_count_q;
        lap_we      = 1'b0;
        clear       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (full_scale) begin
                        state_d = ST_PAUSE;
                    end else begin
                        time_d = bcd_inc(time_q);
                    end
                end
                // Capture stores time_q, i.e. the value before this edge's tick.
                if (lap && !laps_full_w) begin
                    lap_we      = 1'b1;
                    lap_count_d = lap_count_q + 4'd1;
                end
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                // start_stop has priority; at full scale it is simply dropped.
                if (start_stop) begin
                    if (!full_scale) begin
                        state_d = ST_RUN;
                    end
                end else if (lap) begin
                    clear       = 1'b1;
                    state_d     = ST_IDLE;
                    time_d      = '0;
                    presc_d     = '0;
                    lap_count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            time_q      <= '0;
            lap_count_q <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_count_q <= lap_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Lap memory: slot gi holds lap number gi+1.
    // ------------------------------------------------------------------
    bcd_time_t slot_val [NUM_LAPS];

    generate
        for (genvar gi = 0; gi < NUM_LAPS; gi++) begin : g_slot
            bcd_time_t slot_q;

            // Latch the live time when this slot is the next free one; clear wipes it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_q <= '0;
                end else if (clear) begin
                    slot_q <= '0;
                end else if (lap_we && (lap_count_q == 4'(gi))) begin
                    slot_q <= time_q;
                end
            end

            assign slot_val[gi] = slot_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Display source and digit scan
    // ------------------------------------------------------------------
    bcd_time_t       src_time;
    logic            src_dash;
    logic [SW-1:0]   scan_q, scan_d;
    logic [1:0]      idx_q, idx_d;
    logic            scan_wrap;
    logic [3:0]      nibble;
    logic [3:0]      digit_q, digit_d;
    logic [6:0]      display_q, display_d;

    // Pick live time, a filled slot, or dashes for empty/out-of-range slots.
    always_comb begin
        src_time = time_q;
        src_dash = 1'b0;
        if (sel != 4'd0) begin
            src_dash = 1'b1;
            for (int k = 0; k < NUM_LAPS; k++) begin
                if ((sel == 4'(k + 1)) && (sel <= lap_count_q)) begin
                    src_time = slot_val[k];
                    src_dash = 1'b0;
                end
            end
        end
    end

    assign scan_wrap = (scan_q == SCAN_MAX);
    assign scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    assign idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;

    // Map the lit digit position to its BCD nibble and build the next outputs.
    always_comb begin
        case (idx_q)
            2'd0:    nibble = src_time.tenth;
            2'd1:    nibble = src_time.sec_one;
            2'd2:    nibble = src_time.sec_ten;
            default: nibble = src_time.min;
        endcase
        digit_d   = ~(4'b0001 << idx_q);
        display_d = src_dash ? SEG_DASH : seg7(nibble);
    end

    // Free-running scan counter and registered digit/segment drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q    <= '0;
            idx_q     <= 2'd0;
            digit_q   <= 4'b1110;
            display_q <= SEG_ZERO;
        end else begin
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            display_q <= display_d;
        end
    end

    assign DIGIT     = digit_q;
    assign DISPLAY   = display_q;
    assign running   = (state_q == ST_RUN);
    assign lap_count = lap_count_q;
    assign laps_full = laps_full_w;

endmodule

// File: tb/tb_stopwatch_lap_bank.sv
// Scoreboard bench for stopwatch_lap_bank (TICK_DIV=4, SCAN_DIV=2, NUM_LAPS=2, MAX_MIN=0).
// Stimulus pushes expected displays into a queue; the monitor scans the
// multiplexed display and compares every digit and status output.
module tb_stopwatch_lap_bank;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int NUM_LAPS = 2;
    localparam int MAX_MIN  = 0;

    localparam logic [6:0] DASH = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sel = 4'd0;
    logic [3:0] DIGIT;
    logic [6:0] DISPLAY;
    logic       running;
    logic [3:0] lap_count;
    logic       laps_full;

    stopwatch_lap_bank #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .NUM_LAPS (NUM_LAPS),
        .MAX_MIN  (MAX_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .sel        (sel),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .running    (running),
        .lap_count  (lap_count),
        .laps_full  (laps_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              snap;
        string           name;
        logic [3:0]      sel;
        logic [3:0]      digit;
        logic [6:0]      display;
        logic [3:0][6:0] segs;
        logic            run;
        logic [3:0]      lc;
        logic            full;
    } exp_t;

    exp_t sb_q [$];
    bit   mon_busy = 1'b0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cycles(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        cycles(1);
        lap = 1'b0;
    endtask

    task automatic pulse_both();
        start_stop = 1'b1;
        lap        = 1'b1;
        cycles(1);
        start_stop = 1'b0;
        lap        = 1'b0;
    endtask

    // Wait for the monitor to consume everything, then realign to posedge+1.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain: monitor still busy after %0d cycles, required idle", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input string name, input logic [3:0] dig, input logic [6:0] disp,
                             input logic run, input logic [3:0] lc, input logic full);
        exp_t e;
        e.snap    = 1'b1;
        e.name    = name;
        e.sel     = sel;
        e.digit   = dig;
        e.display = disp;
        e.segs    = '0;
        e.run     = run;
        e.lc      = lc;
        e.full    = full;
        sb_q.push_back(e);
    endtask

    task automatic expect_time(input string name, input logic [3:0] s, input int m, input int st,
                               input int so, input int t, input logic run, input logic [3:0] lc,
                               input logic full);
        exp_t e;
        sel       = s;
        e.snap    = 1'b0;
        e.name    = name;
        e.sel     = s;
        e.digit   = '0;
        e.display = '0;
        e.segs[0] = glyph(t);
        e.segs[1] = glyph(so);
        e.segs[2] = glyph(st);
        e.segs[3] = glyph(m);
        e.run     = run;
        e.lc      = lc;
        e.full    = full;
        sb_q.push_back(e);
        drain();
    endtask

    task automatic expect_dash(input string name, input logic [3:0] s, input logic run,
                               input logic [3:0] lc, input logic full);
        exp_t e;
        sel       = s;
        e.snap    = 1'b0;
        e.name    = name;
        e.sel     = s;
        e.digit   = '0;
        e.display = '0;
        for (int i = 0; i < 4; i++) e.segs[i] = DASH;
        e.run     = run;
        e.lc      = lc;
        e.full    = full;
        sb_q.push_back(e);
        drain();
    endtask

    // Monitor: pop one expectation and compare against what the DUT shows.
    initial begin : monitor
        exp_t       e;
        logic [6:0] got [4];
        logic [3:0] seen;
        int         err0;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e        = sb_q.pop_front();
                mon_busy = 1'b1;
                err0     = errors;
                if (e.snap) begin
                    chk({e.name, ".digit"},     32'(DIGIT),     32'(e.digit));
                    chk({e.name, ".display"},   32'(DISPLAY),   32'(e.display));
                    chk({e.name, ".running"},   32'(running),   32'(e.run));
                    chk({e.name, ".lap_count"}, 32'(lap_count), 32'(e.lc));
                    chk({e.name, ".laps_full"}, 32'(laps_full), 32'(e.full));
                end else begin
                    repeat (2) @(negedge clk);
                    seen = 4'b0000;
                    for (int i = 0; i < 4; i++) got[i] = 7'h7f;
                    for (int n = 0; n < 24; n++) begin
                        case (DIGIT)
                            4'b1110: begin got[0] = DISPLAY; seen[0] = 1'b1; end
                            4'b1101: begin got[1] = DISPLAY; seen[1] = 1'b1; end
                            4'b1011: begin got[2] = DISPLAY; seen[2] = 1'b1; end
                            4'b0111: begin got[3] = DISPLAY; seen[3] = 1'b1; end
                            default: ;
                        endcase
                        if (seen == 4'b1111) break;
                        @(negedge clk);
                    end
                    chk({e.name, ".digits_lit"}, 32'(seen),      32'(4'b1111));
                    chk({e.name, ".running"},    32'(running),   32'(e.run));
                    chk({e.name, ".lap_count"},  32'(lap_count), 32'(e.lc));
                    chk({e.name, ".laps_full"},  32'(laps_full), 32'(e.full));
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("%s.seg%0d", e.name, i), 32'(got[i]), 32'(e.segs[i]));
                    end
                end
                $display("%0t %s sel=%0d run=%0b lap_count=%0d bad_fields=%0d",
                         $time, e.name, e.sel, running, lap_count, errors - err0);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset, then watch the digit scan walk 1110 -> 1101 -> 1011 -> 0111.
        cycles(3);
        rst = 1'b0;
        push_snap("reset",  4'b1110, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan1",  4'b1110, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan2",  4'b1110, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan3",  4'b1101, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan4",  4'b1101, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan5",  4'b1011, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan6",  4'b1011, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan7",  4'b0111, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan8",  4'b0111, 7'b1000000, 1'b0, 4'd0, 1'b0);
        push_snap("scan9",  4'b1110, 7'b1000000, 1'b0, 4'd0, 1'b0);
        drain();

        // 100 RUN cycles = 25 ticks, then pause hold and resume by one tick.
        pulse_ss();
        cycles(99);
        pulse_ss();
        expect_time("pause_2.5", 4'd0, 0, 0, 2, 5, 1'b0, 4'd0, 1'b0);
        cycles(40);
        expect_time("hold_2.5",  4'd0, 0, 0, 2, 5, 1'b0, 4'd0, 1'b0);
        pulse_ss();
        cycles(3);
        pulse_ss();
        expect_time("resume_2.6", 4'd0, 0, 0, 2, 6, 1'b0, 4'd0, 1'b0);

        // Clear, then laps at 1.0 and 2.0, a third lap dropped when full.
        pulse_lap();
        expect_time("clear", 4'd0, 0, 0, 0, 0, 1'b0, 4'd0, 1'b0);
        pulse_ss();
        cycles(40);
        pulse_lap();
        cycles(39);
        pulse_lap();
        pulse_lap();
        pulse_ss();
        expect_time("laps_live",  4'd0, 0, 0, 2, 0, 1'b0, 4'd2, 1'b1);
        expect_time("lap1",       4'd1, 0, 0, 1, 0, 1'b0, 4'd2, 1'b1);
        expect_time("lap2",       4'd2, 0, 0, 2, 0, 1'b0, 4'd2, 1'b1);
        expect_dash("lap3_range", 4'd3, 1'b0, 4'd2, 1'b1);

        // Saturation at 0:59.9 and start_stop ignored at full scale.
        pulse_lap();
        pulse_ss();
        cycles(2420);
        expect_time("saturate", 4'd0, 0, 5, 9, 9, 1'b0, 4'd0, 1'b0);
        pulse_ss();
        expect_time("sat_hold", 4'd0, 0, 5, 9, 9, 1'b0, 4'd0, 1'b0);

        // Lap on a tick edge stores the pre-increment value; clear from PAUSE.
        pulse_lap();
        pulse_ss();
        cycles(7);
        pulse_lap();
        pulse_ss();
        expect_time("pre_inc_live", 4'd0, 0, 0, 0, 2, 1'b0, 4'd1, 1'b0);
        expect_time("pre_inc_slot", 4'd1, 0, 0, 0, 1, 1'b0, 4'd1, 1'b0);
        pulse_lap();
        expect_time("cleared",       4'd0, 0, 0, 0, 0, 1'b0, 4'd0, 1'b0);
        expect_dash("cleared_slot1", 4'd1, 1'b0, 4'd0, 1'b0);
        expect_dash("cleared_slot3", 4'd3, 1'b0, 4'd0, 1'b0);

        // Simultaneous pulses: RUN captures then pauses; PAUSE resumes, lap ignored.
        pulse_ss();
        cycles(3);
        pulse_both();
        expect_time("both_run_live", 4'd0, 0, 0, 0, 1, 1'b0, 4'd1, 1'b0);
        expect_time("both_run_slot", 4'd1, 0, 0, 0, 0, 1'b0, 4'd1, 1'b0);
        pulse_both();
        pulse_ss();
        expect_time("both_pause", 4'd0, 0, 0, 0, 1, 1'b0, 4'd1, 1'b0);

        // Asynchronous reset mid-RUN at 0:00.7, between clock edges.
        pulse_lap();
        pulse_ss();
        cycles(4);
        pulse_lap();
        cycles(24);
        #1;
        rst = 1'b1;
        push_snap("async_rst", 4'b1110, 7'b1000000, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain();
        expect_time("post_rst", 4'd0, 0, 0, 0, 0, 1'b0, 4'd0, 1'b0);
        pulse_ss();
        cycles(2);
        pulse_ss();
        expect_time("no_early_tick", 4'd0, 0, 0, 0, 0, 1'b0, 4'd0, 1'b0);
        pulse_ss();
        pulse_ss();
        expect_time("first_tick", 4'd0, 0, 0, 0, 1, 1'b0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
